// File: rtl/add_arbiter_pkg.sv
// Shared types and widths for the shared-adder arbiter: operand/result widths,
// the s1 payload record and the sign-extending add.
package add_arbiter_pkg;

  localparam int OPW     = 31;
  localparam int RW      = OPW + 1;
  localparam int IDMAX_W = 8;

  typedef struct packed {
    logic [OPW-1:0]     a;
    logic [OPW-1:0]     b;
    logic [IDMAX_W-1:0] id;
  } s1_pld_t;

  function automatic logic [RW-1:0] sext_add(input logic [OPW-1:0] a,
                                             input logic [OPW-1:0] b);
    return {a[OPW-1], a} + {b[OPW-1], b};
  endfunction

endpackage

// File: rtl/add_arbiter_rr_arb.sv
// N-wide round-robin arbiter: combinational one-hot grant, search starts after
// the last granted index; ptr advances only when a grant is issued.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (en_i) begin
      for (int k = 1; k <= N; k++) begin
        idx = PW'((int'(ptr_q) + k) % N);
        if (!found && req_i[idx]) begin
          gnt_o[idx] = 1'b1;
          ptr_d      = idx;
          found      = 1'b1;
        end
      end
    end
  end

  // Reset to N-1 so requester 0 is first in the search order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= PW'(N - 1);
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/add_arbiter.sv
// One registered signed adder shared by N requesters; grant to rsp_valid is 2 cycles.
// Backpressure: s2 holds under rsp_ready=0, s1 holds when full, and gnt drops to 0.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [N*OPW-1:0] req_a,
  input  logic [N*OPW-1:0] req_b,
  output logic [N-1:0]     gnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RW-1:0]    rsp_sum,
  output logic [ID_W-1:0]  rsp_id,
  output logic [CNT_W-1:0] done_cnt
);

  logic             s1_vld_q, s1_vld_d;
  s1_pld_t          s1_q, s1_d;
  s1_pld_t          sel_pld;
  logic             rsp_vld_q, rsp_vld_d;
  logic [RW-1:0]    sum_q, sum_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_load;
  logic             s1_accept;

  assign s2_load   = s1_vld_q & (~rsp_vld_q | rsp_ready);
  assign s1_accept = ~s1_vld_q | s2_load;

  // Gating with reset_n keeps gnt low for the whole reset assertion.
  rr_arb #(.N(N)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (s1_accept & reset_n),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  always_comb begin
    sel_pld = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sel_pld.a  = req_a[OPW*i +: OPW];
        sel_pld.b  = req_b[OPW*i +: OPW];
        sel_pld.id = IDMAX_W'(i);
      end
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_d      = s1_q;
    rsp_vld_d = rsp_vld_q;
    sum_d     = sum_q;
    id_d      = id_q;
    if (s1_accept) begin
      s1_vld_d = |gnt;
      s1_d     = sel_pld;
    end
    if (s2_load) begin
      rsp_vld_d = 1'b1;
      sum_d     = sext_add(s1_q.a, s1_q.b);
      id_d      = s1_q.id[ID_W-1:0];
    end else if (rsp_ready) begin
      rsp_vld_d = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(rsp_vld_q & rsp_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      rsp_vld_q <= 1'b0;
      sum_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      rsp_vld_q <= rsp_vld_d;
      sum_q     <= sum_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: table-driven single-requester vectors plus
// round-robin, backpressure, mid-operation reset and counter-wrap sequences.
module tb_add_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req;
  logic [123:0] req_a, req_b;
  logic [3:0]   gnt;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_sum;
  logic [1:0]   rsp_id;
  logic [15:0]  done_cnt;

  logic [3:0]   w_req;
  logic [123:0] w_a, w_b;
  logic [3:0]   w_gnt;
  logic         w_rsp_valid;
  logic         w_rsp_ready;
  logic [31:0]  w_sum;
  logic [1:0]   w_id;
  logic [2:0]   w_done;

  int checks   = 0;
  int failures = 0;
  int exp_done = 0;

  add_arbiter #(.N(4), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .done_cnt(done_cnt)
  );

  add_arbiter #(.N(4), .ID_W(2), .CNT_W(3)) dut_w (
    .clk(clk), .reset_n(reset_n), .req(w_req), .req_a(w_a), .req_b(w_b),
    .gnt(w_gnt), .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
    .rsp_sum(w_sum), .rsp_id(w_id), .done_cnt(w_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [30:0] a;
    logic [30:0] b;
    logic [1:0]  id;
    logic [3:0]  egnt;
    logic [31:0] esum;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{a: 31'd5,          b: 31'h7FFFFFFD, id: 2'd2, egnt: 4'b0100, esum: 32'd2};
    vecs[1] = '{a: 31'h3FFFFFFF,   b: 31'h3FFFFFFF, id: 2'd1, egnt: 4'b0010, esum: 32'h7FFFFFFE};
    vecs[2] = '{a: 31'h40000000,   b: 31'h40000000, id: 2'd3, egnt: 4'b1000, esum: 32'h80000000};
    vecs[3] = '{a: 31'h7FFFFFFF,   b: 31'h7FFFFFFF, id: 2'd0, egnt: 4'b0001, esum: 32'hFFFFFFFE};
    vecs[4] = '{a: 31'h40000000,   b: 31'h3FFFFFFF, id: 2'd3, egnt: 4'b1000, esum: 32'hFFFFFFFF};

    reset_n = 1'b0;
    req = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    w_req = '0; w_a = '0; w_b = '0; w_rsp_ready = 1'b1;
    #2;
    chk("reset_gnt",       32'(gnt),       32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_sum",   rsp_sum,        32'd0);
    chk("reset_rsp_id",    32'(rsp_id),    32'd0);
    chk("reset_done_cnt",  32'(done_cnt),  32'd0);
    req = '0;
    next(); next();
    reset_n = 1'b1;

    // Single-requester vectors, each from an idle pipeline.
    for (int i = 0; i < 5; i++) begin
      next();
      req = 4'b0001 << vecs[i].id;
      req_a[31*vecs[i].id +: 31] = vecs[i].a;
      req_b[31*vecs[i].id +: 31] = vecs[i].b;
      #1;
      chk("vec_gnt", 32'(gnt), 32'(vecs[i].egnt));
      next();
      req = '0;
      #1;
      chk("vec_t1_idle", 32'(rsp_valid), 32'd0);
      next();
      chk("vec_valid", 32'(rsp_valid), 32'd1);
      chk("vec_sum",   rsp_sum,        vecs[i].esum);
      chk("vec_id",    32'(rsp_id),    32'(vecs[i].id));
      exp_done++;
      next();
      chk("vec_drained", 32'(rsp_valid), 32'd0);
      chk("vec_done",    32'(done_cnt),  32'(exp_done));
    end

    // All four requesting from reset: grants 0,1,2,3,0,... and back-to-back responses.
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
    exp_done = 0;
    for (int i = 0; i < 4; i++) begin
      req_a[31*i +: 31] = 31'(i + 1);
      req_b[31*i +: 31] = 31'(100 * i);
    end
    for (int c = 0; c < 10; c++) begin
      next();
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_gnt", 32'(gnt), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 2) begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id",    32'(rsp_id),    32'((c - 2) % 4));
        chk("rr_sum",   rsp_sum,        32'(((c - 2) % 4) + 1 + 100 * ((c - 2) % 4)));
      end
    end
    exp_done += 8;
    next();
    chk("rr_idle", 32'(rsp_valid), 32'd0);
    chk("rr_done", 32'(done_cnt),  32'(exp_done));

    // Backpressure: requesters 1 and 3, rsp_ready low for 5 cycles; ptr is 3 here.
    req_a[31*1 +: 31] = 31'd10;         req_b[31*1 +: 31] = 31'd20;
    req_a[31*3 +: 31] = 31'h7FFFFFF9;   req_b[31*3 +: 31] = 31'd2;
    rsp_ready = 1'b0;
    req = 4'b1010;
    #1;
    chk("bp_gnt0", 32'(gnt), 32'b0010);
    next();
    req = 4'b1000;
    #1;
    chk("bp_gnt1", 32'(gnt), 32'b1000);
    next();
    req = 4'b0010;
    req_a[31*1 +: 31] = 31'd1000;       req_b[31*1 +: 31] = 31'd1;
    for (int c = 2; c < 5; c++) begin
      #1;
      chk("bp_gnt_blocked", 32'(gnt),       32'd0);
      chk("bp_hold_valid",  32'(rsp_valid), 32'd1);
      chk("bp_hold_sum",    rsp_sum,        32'd30);
      chk("bp_hold_id",     32'(rsp_id),    32'd1);
      next();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume_gnt", 32'(gnt),    32'b0010);
    chk("bp_rsp1_sum",   rsp_sum,     32'd30);
    next();
    req = '0;
    #1;
    chk("bp_rsp2_id",  32'(rsp_id), 32'd3);
    chk("bp_rsp2_sum", rsp_sum,     32'hFFFFFFFB);
    next();
    chk("bp_rsp3_id",  32'(rsp_id), 32'd1);
    chk("bp_rsp3_sum", rsp_sum,     32'd1001);
    next();
    exp_done += 3;
    chk("bp_idle", 32'(rsp_valid), 32'd0);
    chk("bp_done", 32'(done_cnt),  32'(exp_done));

    // Reset while s1 and s2 both hold operations.
    req_a[31*0 +: 31] = 31'd3;   req_b[31*0 +: 31] = 31'd4;
    req_a[31*1 +: 31] = 31'd50;  req_b[31*1 +: 31] = 31'h7FFFFFCE;
    rsp_ready = 1'b0;
    req = 4'b0001;
    #1;
    chk("rst_pre_gnt0", 32'(gnt), 32'b0001);
    next();
    req = 4'b0010;
    #1;
    chk("rst_pre_gnt1", 32'(gnt), 32'b0010);
    next();
    req = 4'b0011;
    chk("rst_pre_valid", 32'(rsp_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_valid_now", 32'(rsp_valid), 32'd0);
    chk("rst_done_now",  32'(done_cnt),  32'd0);
    chk("rst_gnt_low",   32'(gnt),       32'd0);
    exp_done = 0;
    next();
    reset_n = 1'b1;
    #1;
    chk("rst_first_gnt", 32'(gnt), 32'b0001);
    next();
    req = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    chk("rst_no_stale",  32'(rsp_valid), 32'd0);
    chk("rst_gnt_next",  32'(gnt),       32'b0010);
    next();
    req = '0;
    chk("rst_rsp0_id",  32'(rsp_id), 32'd0);
    chk("rst_rsp0_sum", rsp_sum,     32'd7);
    next();
    chk("rst_rsp1_id",  32'(rsp_id), 32'd1);
    chk("rst_rsp1_sum", rsp_sum,     32'd0);
    next();
    exp_done += 2;
    chk("rst_idle", 32'(rsp_valid), 32'd0);
    chk("rst_done", 32'(done_cnt),  32'(exp_done));

    // 3-bit counter: 9 back-to-back handshakes end on 7,0,1.
    w_a[30:0] = 31'd1;
    w_b[30:0] = 31'd1;
    for (int c = 0; c < 13; c++) begin
      next();
      w_req = (c < 9) ? 4'b0001 : 4'b0000;
      #1;
      chk("wrap_done", 32'(w_done),
          32'(((c <= 2) ? 0 : ((c - 2 > 9) ? 9 : (c - 2))) % 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
